io_responder: RTL and testbench
===============================

IO_RESPONDER -- requirements
Module: io_responder

Interface
REQ-001 Parameter: BASE_WORD, 16'h000F, word address of the first register; registers occupy BASE_WORD..BASE_WORD+4.
REQ-002 Port: clk  input  1  system clock; all state on rising edge.
REQ-003 Port: resetn  input  1  asynchronous active-low reset.
REQ-004 Port: W  input  1  processor write strobe.
REQ-005 Port: realaddr  input  32  processor byte address; word address = realaddr>>2, bits [15:0] decoded.
REQ-006 Port: dout  input  32  processor write data.
REQ-007 Port: din  output  32  read data to processor.
REQ-008 Port: hit  output  1  din is valid this cycle; top selects din from this block instead of memory.
REQ-009 Port: SW  input  10  asynchronous slide switches.
REQ-010 Port: KEY  input  4  asynchronous pushbuttons, active-low.
REQ-011 Port: LEDR  output  10  LED register.

Function
REQ-012 Register map (word offset from BASE_WORD): 0 LED (RW, bits[9:0]), 1 SW (RO), 2 KEYEDGE (RW1C, bits[3:0]), 3 TLOAD (RW, 32 bits), 4 TCTRL (bit0 EN, bit1 AUTO, bit31 TO RW1C).
REQ-013 Write occurs in the cycle W=1 and the word address matches; non-matching addresses are ignored.
REQ-014 Read has one-cycle latency, matching memory: the cycle after any in-range access with W=0, hit=1 and din holds the addressed register; otherwise hit=0 and din=0.
REQ-015 Unused register bits read 0; writes to SW are ignored.
REQ-016 SW and KEY pass through 2-flop synchronisers before any use.
REQ-017 KEYEDGE bit n sets on a synchronised 1->0 transition of KEY[n]; writing 1 clears it; a set and a clear in the same cycle leaves the bit set.
REQ-018 Timer: 32-bit down counter. A TLOAD write also loads the counter with dout.
REQ-019 With EN=1 and count!=0, the counter decrements by 1 per cycle.
REQ-020 With EN=1 and count==0: TO sets; if AUTO=1 the counter reloads TLOAD; if AUTO=0 EN clears and the counter holds 0.
REQ-021 A TO set and a TO write-1 clear in the same cycle leave TO set.
REQ-022 TLOAD=0 with AUTO=1 sets TO every cycle while EN=1.
REQ-023 A TCTRL write updates EN/AUTO in the same cycle as any TO clear; the counter value is unaffected.

Reset
REQ-024 While resetn=0: LEDR=0, din=0, hit=0, KEYEDGE=0, TLOAD=0, counter=0, TCTRL=0, and synchroniser flops=0 (KEY synchroniser=4'hF).
REQ-025 Reset asserted mid-operation aborts the pending read response: hit is 0 in the cycle after release.

Configuration
REQ-026 Macro IO_TIMER_EN: when defined, TLOAD, TCTRL and the counter are present as specified.
REQ-027 Without IO_TIMER_EN: offsets 3 and 4 read 0 with hit=1, writes to them are ignored, and no timer flops are synthesised.

Structure
REQ-028 A shared package holds register offset constants (LED, SW, KEYEDGE, TLOAD, TCTRL) and TCTRL bit positions.
REQ-029 The timer is a sub-module io_timer (load, enable, auto, clear-TO in; count, TO out), instantiated only under IO_TIMER_EN.

Verification
REQ-030 Write 32'h3FF to the LED word (byte address 0x3C), then read -> LEDR=10'h3FF; next cycle din=32'h3FF, hit=1.
REQ-031 SW=10'h155 held -> read of SW word returns 32'h155; a read at BASE_WORD+5 -> hit=0.
REQ-032 Pulse KEY[2] low for 3 cycles -> KEYEDGE=4'h4; write 4'h4 coincident with a new KEY[2] edge -> remains 4'h4; plain write 4'h4 -> 0.
REQ-033 TLOAD=3, TCTRL=3 (EN and AUTO) -> TO sets 4 cycles after enable; counter reloads 3; write TCTRL=32'h8000_0003 -> TO clears.
REQ-034 TLOAD=2, TCTRL=1 (EN only) -> TO sets, EN clears, counter holds 0.
REQ-035 Assert resetn=0 in the cycle after a read request -> all outputs 0 and no hit after release; without IO_TIMER_EN, TCTRL reads 0.

Source files
------------

// File: rtl/io_responder_pkg.sv
// -----------------------------------------------------------------------------
// io_responder_pkg
// Shared definitions for the memory-mapped I/O responder: register word
// offsets relative to BASE_WORD and TCTRL bit positions.
// -----------------------------------------------------------------------------
package io_responder_pkg;

    // Word offsets from BASE_WORD.
    typedef enum logic [2:0] {
        OFF_LED     = 3'd0,
        OFF_SW      = 3'd1,
        OFF_KEYEDGE = 3'd2,
        OFF_TLOAD   = 3'd3,
        OFF_TCTRL   = 3'd4
    } reg_off_e;

    localparam logic [15:0] NUM_REGS = 16'd5;

    // TCTRL bit positions.
    localparam int TCTRL_EN_BIT   = 0;
    localparam int TCTRL_AUTO_BIT = 1;
    localparam int TCTRL_TO_BIT   = 31;

    // Zero-extend a 10-bit field onto the 32-bit read bus.
    function automatic logic [31:0] zext10(input logic [9:0] v);
        return {22'b0, v};
    endfunction

endpackage

// File: rtl/io_responder_timer.sv
// -----------------------------------------------------------------------------
// io_timer
// 32-bit down counter with reload register and EN/AUTO/TO control.
// Ports:
//   clk, resetn     clock, asynchronous active-low reset
//   load            TLOAD write strobe: sets TLOAD and the counter to load_value
//   load_value      TLOAD write data
//   ctrl_write      TCTRL write strobe: updates EN and AUTO
//   enable          new EN value (valid with ctrl_write)
//   auto_reload     new AUTO value (valid with ctrl_write)
//   clear_to        write-1-clear of TO
//   count           current counter value
//   tload           reload register
//   en, auto_q, to  TCTRL state
// -----------------------------------------------------------------------------
module io_timer (
    input  logic        clk,
    input  logic        resetn,
    input  logic        load,
    input  logic [31:0] load_value,
    input  logic        ctrl_write,
    input  logic        enable,
    input  logic        auto_reload,
    input  logic        clear_to,
    output logic [31:0] count,
    output logic [31:0] tload,
    output logic        en,
    output logic        auto_q,
    output logic        to
);

    logic expired;
    assign expired = en && (count == '0);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count  <= '0;
            tload  <= '0;
            en     <= 1'b0;
            auto_q <= 1'b0;
            to     <= 1'b0;
        end else begin
            // A TLOAD write takes precedence over decrement/reload.
            if (load) begin
                tload <= load_value;
                count <= load_value;
            end else if (expired) begin
                if (auto_q)
                    count <= tload;
            end else if (en) begin
                count <= count - 32'd1;
            end

            // A software TCTRL write overrides the one-shot auto-disable.
            if (ctrl_write) begin
                en     <= enable;
                auto_q <= auto_reload;
            end else if (expired && !auto_q) begin
                en <= 1'b0;
            end

            // Setting wins over a coincident write-1 clear.
            if (expired)
                to <= 1'b1;
            else if (clear_to)
                to <= 1'b0;
        end
    end

endmodule

// File: rtl/io_responder.sv
// -----------------------------------------------------------------------------
// io_responder
// Memory-mapped I/O block: LED register, synchronised slide switches,
// pushbutton falling-edge capture and (optionally) an interval timer.
// Reads return one cycle after the request, like the memory they sit beside.
// Optional feature macro: IO_TIMER_EN (adds TLOAD/TCTRL and the io_timer).
// Ports:
//   clk, resetn   clock, asynchronous active-low reset
//   W             processor write strobe
//   realaddr      processor byte address (word address = realaddr[17:2])
//   dout          processor write data
//   din           registered read data (0 when hit=0)
//   hit           din is valid this cycle
//   SW            asynchronous slide switches
//   KEY           asynchronous active-low pushbuttons
//   LEDR          LED register
// -----------------------------------------------------------------------------
module io_responder
    import io_responder_pkg::*;
#(
    parameter logic [15:0] BASE_WORD = 16'h000F
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        W,
    input  logic [31:0] realaddr,
    input  logic [31:0] dout,
    output logic [31:0] din,
    output logic        hit,
    input  logic [9:0]  SW,
    input  logic [3:0]  KEY,
    output logic [9:0]  LEDR
);

    // Address decode: unsigned wrap makes addresses below BASE_WORD out of range.
    logic [15:0] word_addr;
    logic [15:0] offset;
    logic        in_range;
    reg_off_e    sel;
    logic        wr;
    logic        rd;

    assign word_addr = realaddr[17:2];
    assign offset    = word_addr - BASE_WORD;
    assign in_range  = offset < NUM_REGS;
    assign sel       = reg_off_e'(offset[2:0]);
    assign wr        = W && in_range;
    assign rd        = !W && in_range;

    logic unused_bits;
    assign unused_bits = ^{realaddr[31:18], realaddr[1:0], dout[31:10]};

    logic [9:0] sw_meta, sw_sync;
    logic [3:0] key_meta, key_sync, key_prev;
    logic [9:0] led;
    logic [3:0] keyedge;
    logic [3:0] key_fall;
    logic [3:0] keyedge_clr;
    logic [31:0] tload_rd;
    logic [31:0] tctrl_rd;
    logic [31:0] rd_data;

    assign key_fall    = key_prev & ~key_sync;
    assign keyedge_clr = (wr && sel == OFF_KEYEDGE) ? dout[3:0] : 4'b0;
    assign LEDR        = led;

`ifdef IO_TIMER_EN
    logic [31:0] tload;
    logic [31:0] unused_count;
    logic        t_en, t_auto, t_to;

    io_timer u_timer (
        .clk         (clk),
        .resetn      (resetn),
        .load        (wr && sel == OFF_TLOAD),
        .load_value  (dout),
        .ctrl_write  (wr && sel == OFF_TCTRL),
        .enable      (dout[TCTRL_EN_BIT]),
        .auto_reload (dout[TCTRL_AUTO_BIT]),
        .clear_to    (wr && sel == OFF_TCTRL && dout[TCTRL_TO_BIT]),
        .count       (unused_count),
        .tload       (tload),
        .en          (t_en),
        .auto_q      (t_auto),
        .to          (t_to)
    );

    always_comb begin
        tctrl_rd                 = '0;
        tctrl_rd[TCTRL_EN_BIT]   = t_en;
        tctrl_rd[TCTRL_AUTO_BIT] = t_auto;
        tctrl_rd[TCTRL_TO_BIT]   = t_to;
    end
    assign tload_rd = tload;
`else
    // Timer absent: offsets 3 and 4 still respond, reading 0.
    assign tload_rd = '0;
    assign tctrl_rd = '0;
`endif

    always_comb begin
        // NOTE: default assignment first so every path drives rd_data; no latch.
        rd_data = '0;
        case (sel)
            OFF_LED:     rd_data = zext10(led);
            OFF_SW:      rd_data = zext10(sw_sync);
            OFF_KEYEDGE: rd_data = {28'b0, keyedge};
            OFF_TLOAD:   rd_data = tload_rd;
            OFF_TCTRL:   rd_data = tctrl_rd;
            default:     rd_data = '0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sw_meta  <= '0;
            sw_sync  <= '0;
            // Buttons idle high, so their synchroniser idles high too and
            // reset release cannot fake a falling edge.
            key_meta <= 4'hF;
            key_sync <= 4'hF;
            key_prev <= 4'hF;
            led      <= '0;
            keyedge  <= '0;
            hit      <= 1'b0;
            din      <= '0;
        end else begin
            sw_meta  <= SW;
            sw_sync  <= sw_meta;
            key_meta <= KEY;
            key_sync <= key_meta;
            key_prev <= key_sync;

            if (wr && sel == OFF_LED)
                led <= dout[9:0];

            // New edge is OR'd in after the clear, so set wins.
            keyedge <= (keyedge & ~keyedge_clr) | key_fall;

            hit <= rd;
            din <= rd ? rd_data : '0;
        end
    end

endmodule

// File: tb/tb_io_responder.sv
// -----------------------------------------------------------------------------
// tb_io_responder
// Directed self-checking bench for io_responder. Inputs change on the falling
// edge and outputs are sampled on the falling edge, away from the active edge.
// -----------------------------------------------------------------------------
module tb_io_responder;
    import io_responder_pkg::*;

    localparam logic [15:0] BASE = 16'h000F;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        W = 1'b0;
    logic [31:0] realaddr = '0;
    logic [31:0] dout = '0;
    logic [31:0] din;
    logic        hit;
    logic [9:0]  SW = '0;
    logic [3:0]  KEY = 4'hF;
    logic [9:0]  LEDR;

    int errors = 0;
    int checks = 0;

    io_responder #(.BASE_WORD(BASE)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .W        (W),
        .realaddr (realaddr),
        .dout     (dout),
        .din      (din),
        .hit      (hit),
        .SW       (SW),
        .KEY      (KEY),
        .LEDR     (LEDR)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] byte_addr(input int off);
        return 32'((int'(BASE) + off) * 4);
    endfunction

    task automatic drive(input logic w, input int off, input logic [31:0] data);
        W        = w;
        realaddr = byte_addr(off);
        dout     = data;
    endtask

    task automatic idle();
        W        = 1'b0;
        realaddr = '0;
        dout     = '0;
    endtask

    task automatic bus_write(input int off, input logic [31:0] data);
        @(negedge clk);
        drive(1'b1, off, data);
        @(negedge clk);
        idle();
    endtask

    task automatic bus_read(input string tag, input int off, input logic [31:0] exp,
                            input logic exp_hit);
        @(negedge clk);
        drive(1'b0, off, '0);
        @(negedge clk);
        check({tag, ".hit"}, 32'(hit), 32'(exp_hit));
        check({tag, ".din"}, din, exp);
        idle();
    endtask

    initial begin
        // ---------------- reset state ----------------
        #12;
        check("rst.ledr", 32'(LEDR), 32'h0);
        check("rst.hit",  32'(hit),  32'h0);
        check("rst.din",  din,       32'h0);
        @(negedge clk);
        resetn = 1'b1;

        // ---------------- LED ----------------
        @(negedge clk);
        W = 1'b1; realaddr = 32'h0000_003C; dout = 32'h0000_03FF;
        @(negedge clk);
        idle();
        check("led.write", 32'(LEDR), 32'h3FF);
        check("led.wr_nohit", 32'(hit), 32'h0);
        bus_read("led.read", int'(OFF_LED), 32'h3FF, 1'b1);

        bus_write(int'(OFF_LED), 32'hFFFF_F0A5);
        check("led.trunc", 32'(LEDR), 32'h0A5);
        bus_read("led.read2", int'(OFF_LED), 32'h0A5, 1'b1);

        // Out-of-range above and below the window.
        bus_write(5, 32'h0000_0111);
        check("led.oor_write", 32'(LEDR), 32'h0A5);
        bus_read("oor.above", 5, 32'h0, 1'b0);
        bus_read("oor.below", -1, 32'h0, 1'b0);

        // ---------------- SW ----------------
        SW = 10'h155;
        repeat (3) @(negedge clk);
        bus_read("sw.read", int'(OFF_SW), 32'h155, 1'b1);
        bus_write(int'(OFF_SW), 32'h0);
        bus_read("sw.ro", int'(OFF_SW), 32'h155, 1'b1);

        // ---------------- KEYEDGE ----------------
        @(negedge clk); KEY[2] = 1'b0;
        repeat (3) @(negedge clk);
        KEY[2] = 1'b1;
        repeat (4) @(negedge clk);
        bus_read("key.set", int'(OFF_KEYEDGE), 32'h4, 1'b1);

        // Clear lands on the same edge that captures a new fall: stays set.
        @(negedge clk); KEY[2] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        drive(1'b1, int'(OFF_KEYEDGE), 32'h4);
        @(negedge clk);
        idle();
        repeat (2) @(negedge clk);
        KEY[2] = 1'b1;
        repeat (4) @(negedge clk);
        bus_read("key.set_wins", int'(OFF_KEYEDGE), 32'h4, 1'b1);

        bus_write(int'(OFF_KEYEDGE), 32'h4);
        bus_read("key.clear", int'(OFF_KEYEDGE), 32'h0, 1'b1);

        @(negedge clk); KEY = 4'b0110;
        repeat (3) @(negedge clk);
        KEY = 4'hF;
        repeat (4) @(negedge clk);
        bus_read("key.multi", int'(OFF_KEYEDGE), 32'h9, 1'b1);
        bus_write(int'(OFF_KEYEDGE), 32'h1);
        bus_read("key.partial_clr", int'(OFF_KEYEDGE), 32'h8, 1'b1);

        // ---------------- timer ----------------
`ifdef IO_TIMER_EN
        begin
            logic [31:0] exp_count [5] = '{32'd2, 32'd1, 32'd0, 32'd3, 32'd2};
            bus_write(int'(OFF_TLOAD), 32'd3);
            bus_read("tmr.tload", int'(OFF_TLOAD), 32'd3, 1'b1);
            bus_write(int'(OFF_TCTRL), 32'h3);      // enable edge is P0
            drive(1'b0, int'(OFF_TCTRL), '0);       // back-to-back TCTRL reads
            for (int k = 1; k <= 5; k++) begin
                @(negedge clk);                     // after P0+k
                check($sformatf("tmr.count%0d", k), dut.u_timer.count, exp_count[k-1]);
                // din shows state after P0+k-1; TO sets at P0+4.
                check($sformatf("tmr.tctrl%0d", k), din,
                      (k == 5) ? 32'h8000_0003 : 32'h0000_0003);
            end
            drive(1'b1, int'(OFF_TCTRL), 32'h8000_0003);   // lands at P0+6, count 2->1
            @(negedge clk);
            drive(1'b0, int'(OFF_TCTRL), '0);
            @(negedge clk);
            check("tmr.to_clear", din, 32'h0000_0003);
            drive(1'b1, int'(OFF_TCTRL), 32'h8000_0003);   // lands at P0+8, expiry
            @(negedge clk);
            drive(1'b0, int'(OFF_TCTRL), '0);
            @(negedge clk);
            check("tmr.to_set_wins", din, 32'h8000_0003);
            idle();

            bus_write(int'(OFF_TCTRL), 32'h0);
            bus_write(int'(OFF_TCTRL), 32'h8000_0000);
            bus_read("tmr.stopped", int'(OFF_TCTRL), 32'h0, 1'b1);

            bus_write(int'(OFF_TLOAD), 32'd2);
            bus_write(int'(OFF_TCTRL), 32'h1);
            repeat (6) @(negedge clk);
            bus_read("tmr.oneshot", int'(OFF_TCTRL), 32'h8000_0000, 1'b1);
            check("tmr.hold0", dut.u_timer.count, 32'd0);
            bus_read("tmr.tload2", int'(OFF_TLOAD), 32'd2, 1'b1);
        end
`else
        bus_read("notmr.tload", int'(OFF_TLOAD), 32'h0, 1'b1);
        bus_write(int'(OFF_TLOAD), 32'h0000_1234);
        bus_read("notmr.tload_wr", int'(OFF_TLOAD), 32'h0, 1'b1);
        bus_write(int'(OFF_TCTRL), 32'h8000_0003);
        bus_read("notmr.tctrl", int'(OFF_TCTRL), 32'h0, 1'b1);
`endif

        // ---------------- reset during a pending read ----------------
        bus_write(int'(OFF_LED), 32'h3FF);
        @(negedge clk);
        drive(1'b0, int'(OFF_LED), '0);
        @(posedge clk);
        #1;
        check("mid.pending_hit", 32'(hit), 32'h1);
        resetn = 1'b0;
        idle();
        #1;
        check("mid.rst_hit",  32'(hit),  32'h0);
        check("mid.rst_din",  din,       32'h0);
        check("mid.rst_ledr", 32'(LEDR), 32'h0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        check("mid.post_hit", 32'(hit), 32'h0);
        check("mid.post_din", din,      32'h0);
        bus_read("mid.keyedge", int'(OFF_KEYEDGE), 32'h0, 1'b1);
        bus_read("mid.tctrl",   int'(OFF_TCTRL),   32'h0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
